// File: rtl/riscy_pkg.sv
// Shared defaults and requester identifiers for the write-back path.
// Revision: 1.0
`default_nettype none
package riscy_pkg;
  localparam int DATAWIDTH_DEF = 32;
  localparam int REGISTERS_DEF = 32;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;
endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on reservation, cleared on write-back.
// Revision: 1.0
`default_nettype none
module regfile_scoreboard #(
  parameter int REGISTERS = 32,
  parameter int INDEX     = $clog2(REGISTERS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [INDEX-1:0] set_addr,
  input  logic             clr_en,
  input  logic [INDEX-1:0] clr_addr,
  input  logic [INDEX-1:0] chk_addr_1,
  input  logic [INDEX-1:0] chk_addr_2,
  output logic             chk_busy_1,
  output logic             chk_busy_2
);

  logic [REGISTERS-1:0] busy_q;
  logic [REGISTERS-1:0] busy_d;

  // Set is applied after clear so a same-cycle reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign chk_busy_1 = (chk_addr_1 != '0) && busy_q[chk_addr_1];
  assign chk_busy_2 = (chk_addr_2 != '0) && busy_q[chk_addr_2];

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file write-back arbiter with a hazard scoreboard.
// Define WB_ROUND_ROBIN_EN for round-robin contention; otherwise A has fixed priority.
// Revision: 1.0
`default_nettype none
module regfile_wb_arbiter
  import riscy_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int REGISTERS = REGISTERS_DEF,
  parameter int INDEX     = $clog2(REGISTERS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [INDEX-1:0]     a_addr,
  input  logic [DATAWIDTH-1:0] a_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [INDEX-1:0]     b_addr,
  input  logic [DATAWIDTH-1:0] b_data,
  input  logic                 rsv_valid,
  input  logic [INDEX-1:0]     rsv_addr,
  input  logic [INDEX-1:0]     chk_addr_1,
  input  logic [INDEX-1:0]     chk_addr_2,
  output logic                 chk_busy_1,
  output logic                 chk_busy_2,
  output logic                 werf,
  output logic [INDEX-1:0]     wa,
  output logic [DATAWIDTH-1:0] wd
);

  logic                 werf_q, werf_d;
  logic [INDEX-1:0]     wa_q, wa_d;
  logic [DATAWIDTH-1:0] wd_q, wd_d;
  req_id_e              sel;
  logic                 xfer;

`ifdef WB_ROUND_ROBIN_EN
  // Pointer names the requester that wins the next contention.
  req_id_e prio_q, prio_d;

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (rst_n) begin
      a_ready = a_valid && (!b_valid || (prio_q == REQ_A));
      b_ready = b_valid && (!a_valid || (prio_q == REQ_B));
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (a_ready)      prio_d = REQ_B;
    else if (b_ready) prio_d = REQ_A;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= REQ_A;
    else        prio_q <= prio_d;
  end
`else
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (rst_n) begin
      a_ready = a_valid;
      b_ready = b_valid && !a_valid;
    end
  end
`endif

  assign sel  = a_ready ? REQ_A : REQ_B;
  assign xfer = a_ready || b_ready;

  always_comb begin
    werf_d = 1'b0;
    wa_d   = wa_q;
    wd_d   = wd_q;
    if (xfer) begin
      wa_d   = (sel == REQ_A) ? a_addr : b_addr;
      wd_d   = (sel == REQ_A) ? a_data : b_data;
      werf_d = (wa_d != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      werf_q <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
    end else begin
      werf_q <= werf_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
    end
  end

  assign werf = werf_q;
  assign wa   = wa_q;
  assign wd   = wd_q;

  regfile_scoreboard #(
    .REGISTERS (REGISTERS),
    .INDEX     (INDEX)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (rsv_valid),
    .set_addr   (rsv_addr),
    .clr_en     (werf_q),
    .clr_addr   (wa_q),
    .chk_addr_1 (chk_addr_1),
    .chk_addr_2 (chk_addr_2),
    .chk_busy_1 (chk_busy_1),
    .chk_busy_2 (chk_busy_2)
  );

endmodule
`default_nettype wire
